// File: rtl/panda_pkg.sv
// Shared types for the panda execution units: multiply/divide operators and FSM states.
package panda_pkg;

    typedef enum logic [2:0] {
        MD_MUL,
        MD_MULH,
        MD_MULHSU,
        MD_MULHU,
        MD_DIV,
        MD_DIVU,
        MD_REM,
        MD_REMU
    } md_operator_e;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_CALC,
        MD_DONE
    } md_state_e;

    function automatic logic md_is_div(input md_operator_e op);
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

endpackage

// File: rtl/panda_muldiv.sv
// Iterative radix-2 multiply/divide unit (RV-M operator set) with valid/ready handshakes
// and abort; one shift-add or shift-subtract-restore step per cycle on operand magnitudes.
module panda_muldiv
    import panda_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter bit          EARLY_OUT = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       operator_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    input  logic             abort_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o
);

    localparam int unsigned CW = $clog2(WIDTH);

    md_state_e          state_q, state_d;
    md_operator_e       op_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   result_q;
    logic               neg_q, neg_rem_q, special_q;
    logic [CW-1:0]      cnt_q;

    md_operator_e       op_in;
    logic               accept;
    logic               a_signed, b_signed, sa, sb;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               div_zero, overflow, special;
    logic [WIDTH-1:0]   spec_res;

    logic               is_div_q;
    logic [WIDTH:0]     add_x, add_y, add_r;
    logic [2*WIDTH-1:0] acc_step, prod;
    logic [WIDTH-1:0]   quo, rem, final_res;

    // Request decode: magnitudes, result signs and the special cases are fixed at accept.
    always_comb begin
        op_in    = md_operator_e'(operator_i);
        accept   = in_valid_i && (state_q == MD_IDLE) && !abort_i;
        a_signed = !(op_in inside {MD_MULHU, MD_DIVU, MD_REMU});
        b_signed = op_in inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
        sa       = a_signed && operand_a_i[WIDTH-1];
        sb       = b_signed && operand_b_i[WIDTH-1];
        a_mag    = sa ? -operand_a_i : operand_a_i;
        b_mag    = sb ? -operand_b_i : operand_b_i;
        div_zero = md_is_div(op_in) && (operand_b_i == '0);
        overflow = (op_in inside {MD_DIV, MD_REM})
                   && (operand_a_i == {1'b1, {(WIDTH-1){1'b0}}})
                   && (operand_b_i == '1);
        special  = div_zero || overflow;
        if (div_zero)
            spec_res = (op_in inside {MD_DIV, MD_DIVU}) ? '1 : operand_a_i;
        else
            spec_res = (op_in == MD_DIV) ? operand_a_i : '0;
    end

    // One shared WIDTH+1-bit adder: add for multiply, trial subtract for divide.
    always_comb begin
        is_div_q = md_is_div(op_q);
        add_x    = is_div_q ? acc_q[2*WIDTH-1:WIDTH-1] : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        add_y    = {1'b0, b_q};
        add_r    = is_div_q ? (add_x - add_y) : (add_x + add_y);
        if (is_div_q)
            acc_step = add_r[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                    : {add_r[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else
            acc_step = acc_q[0] ? {add_r, acc_q[WIDTH-1:1]}
                                : {1'b0, acc_q[2*WIDTH-1:1]};
        prod = neg_q ? -acc_step : acc_step;
        quo  = acc_step[WIDTH-1:0];
        rem  = acc_step[2*WIDTH-1:WIDTH];
        case (op_q)
            MD_MUL:                       final_res = prod[WIDTH-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: final_res = prod[2*WIDTH-1:WIDTH];
            MD_DIV, MD_DIVU:              final_res = neg_q ? -quo : quo;
            default:                      final_res = neg_rem_q ? -rem : rem;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= MD_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (accept) state_d = (EARLY_OUT && special) ? MD_DONE : MD_CALC;
            MD_CALC: if (cnt_q == '0) state_d = MD_DONE;
            MD_DONE: if (out_ready_i) state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
        if (abort_i) state_d = MD_IDLE;
    end

    // Special-case results are parked in result_q at accept; the iteration leaves them alone.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q      <= MD_MUL;
            acc_q     <= '0;
            b_q       <= '0;
            result_q  <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            special_q <= 1'b0;
            cnt_q     <= '0;
        end else if (accept) begin
            op_q      <= op_in;
            acc_q     <= {{WIDTH{1'b0}}, a_mag};
            b_q       <= b_mag;
            neg_q     <= sa ^ sb;
            neg_rem_q <= sa;
            special_q <= special;
            cnt_q     <= CW'(WIDTH - 1);
            if (special) result_q <= spec_res;
        end else if (state_q == MD_CALC) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q - 1'b1;
            if ((cnt_q == '0) && !special_q) result_q <= final_res;
        end
    end

    assign in_ready_o  = (state_q == MD_IDLE);
    assign out_valid_o = (state_q == MD_DONE) && !abort_i;
    assign result_o    = result_q;

endmodule

// File: tb/tb_panda_muldiv.sv
// Directed bench for panda_muldiv: one instance with early-out, one with full latency.
module tb_panda_muldiv;
    import panda_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_valid0 = 1'b0;
    logic        in_ready, in_ready0;
    logic [2:0]  operator = 3'd0;
    logic [31:0] a = '0, b = '0;
    logic        abort = 1'b0;
    logic        out_valid, out_valid0;
    logic        out_ready = 1'b0, out_ready0 = 1'b0;
    logic [31:0] result, result0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    panda_muldiv #(.WIDTH(32), .EARLY_OUT(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .operator_i(operator), .operand_a_i(a), .operand_b_i(b), .abort_i(abort),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result)
    );

    panda_muldiv #(.WIDTH(32), .EARLY_OUT(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid0), .in_ready_o(in_ready0),
        .operator_i(operator), .operand_a_i(a), .operand_b_i(b), .abort_i(abort),
        .out_valid_o(out_valid0), .out_ready_i(out_ready0), .result_o(result0)
    );

    vec_t mul_vecs[9] = '{
        '{MD_MUL,    32'd30,         32'd3,          32'd90,         33},
        '{MD_MULH,   32'hFFFFFFC2,   32'd5,          32'hFFFFFFFF,   33},
        '{MD_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   33},
        '{MD_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF,   33},
        '{MD_MUL,    32'd7,          32'hFFFFFFFD,   32'hFFFFFFEB,   33},
        '{MD_MULH,   32'h40000000,   32'd4,          32'd1,          33},
        '{MD_MULHSU, 32'h80000000,   32'd2,          32'hFFFFFFFF,   33},
        '{MD_MULHU,  32'h80000000,   32'd2,          32'd1,          33},
        '{MD_MULH,   32'h80000000,   32'h80000000,   32'h40000000,   33}
    };

    vec_t div_vecs[10] = '{
        '{MD_DIV,  32'hFFFFFF7A, 32'hFFFFFFA6, 32'd1,        33},
        '{MD_REM,  32'hFFFFFF7A, 32'hFFFFFFA6, 32'hFFFFFFD4, 33},
        '{MD_DIVU, 32'd30,       32'd50,       32'd0,        33},
        '{MD_REMU, 32'd30,       32'd50,       32'd30,       33},
        '{MD_DIV,  32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33},
        '{MD_REM,  32'd100,      32'hFFFFFFF9, 32'd2,        33},
        '{MD_DIV,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 33},
        '{MD_REM,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 33},
        '{MD_DIVU, 32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF, 33},
        '{MD_REMU, 32'hFFFFFFFF, 32'd16,       32'd15,       33}
    };

    vec_t early_vecs[7] = '{
        '{MD_DIVU, 32'd7,        32'd0,        32'hFFFFFFFF, 1},
        '{MD_REM,  32'd7,        32'd0,        32'd7,        1},
        '{MD_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},
        '{MD_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        1},
        '{MD_DIV,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1},
        '{MD_REMU, 32'h80000000, 32'd0,        32'h80000000, 1},
        '{MD_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33}
    };

    vec_t full_vecs[5] = '{
        '{MD_DIVU, 32'd7,        32'd0,        32'hFFFFFFFF, 33},
        '{MD_REM,  32'd7,        32'd0,        32'd7,        33},
        '{MD_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33},
        '{MD_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        33},
        '{MD_MUL,  32'd30,       32'd3,        32'd90,       33}
    };

    // Stimulus driver: starts and ends at a falling edge; lat = -1 if no result in 100 cycles.
    task automatic do_op(input bit sel, input logic [2:0] op, input logic [31:0] x,
                         input logic [31:0] y, output logic [31:0] res, output int lat);
        operator = op; a = x; b = y;
        if (sel) in_valid0 = 1'b1; else in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; in_valid0 = 1'b0;
        lat = -1;
        res = 'x;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if ((sel ? out_valid0 : out_valid) === 1'b1) begin
                lat = i;
                res = sel ? result0 : result;
                break;
            end
        end
        if (sel) out_ready0 = 1'b1; else out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0; out_ready0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (result !== 32'd0) begin n_err++; $display("FAIL reset_result got %h want 0", result); end
        n_cmp++; if (in_ready0 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready0 got %b want 1", in_ready0); end
    endtask

    task automatic test_mul();
        logic [31:0] r;
        int          l;
        foreach (mul_vecs[i]) begin
            do_op(1'b0, mul_vecs[i].op, mul_vecs[i].a, mul_vecs[i].b, r, l);
            n_cmp++; if (r !== mul_vecs[i].exp) begin n_err++; $display("FAIL mul[%0d] result got %h want %h", i, r, mul_vecs[i].exp); end
            n_cmp++; if (l !== mul_vecs[i].lat) begin n_err++; $display("FAIL mul[%0d] latency got %0d want %0d", i, l, mul_vecs[i].lat); end
        end
    endtask

    task automatic test_div();
        logic [31:0] r;
        int          l;
        foreach (div_vecs[i]) begin
            do_op(1'b0, div_vecs[i].op, div_vecs[i].a, div_vecs[i].b, r, l);
            n_cmp++; if (r !== div_vecs[i].exp) begin n_err++; $display("FAIL div[%0d] result got %h want %h", i, r, div_vecs[i].exp); end
            n_cmp++; if (l !== div_vecs[i].lat) begin n_err++; $display("FAIL div[%0d] latency got %0d want %0d", i, l, div_vecs[i].lat); end
        end
    endtask

    task automatic test_early_out();
        logic [31:0] r;
        int          l;
        foreach (early_vecs[i]) begin
            do_op(1'b0, early_vecs[i].op, early_vecs[i].a, early_vecs[i].b, r, l);
            n_cmp++; if (r !== early_vecs[i].exp) begin n_err++; $display("FAIL early[%0d] result got %h want %h", i, r, early_vecs[i].exp); end
            n_cmp++; if (l !== early_vecs[i].lat) begin n_err++; $display("FAIL early[%0d] latency got %0d want %0d", i, l, early_vecs[i].lat); end
        end
    endtask

    task automatic test_full_latency();
        logic [31:0] r;
        int          l;
        foreach (full_vecs[i]) begin
            do_op(1'b1, full_vecs[i].op, full_vecs[i].a, full_vecs[i].b, r, l);
            n_cmp++; if (r !== full_vecs[i].exp) begin n_err++; $display("FAIL full[%0d] result got %h want %h", i, r, full_vecs[i].exp); end
            n_cmp++; if (l !== full_vecs[i].lat) begin n_err++; $display("FAIL full[%0d] latency got %0d want %0d", i, l, full_vecs[i].lat); end
        end
    endtask

    task automatic test_backpressure();
        int          l;
        logic [31:0] r;
        operator = MD_MUL; a = 32'd30; b = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        #1 a = 32'd5; b = 32'd6;
        l = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin l = i; break; end
        end
        n_cmp++; if (l !== 33) begin n_err++; $display("FAIL bp_latency got %0d want 33", l); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid[%0d] got %b want 1", k, out_valid); end
            n_cmp++; if (result !== 32'd90) begin n_err++; $display("FAIL bp_hold_result[%0d] got %h want 0000005a", k, result); end
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d] got %b want 0", k, in_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_idle_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_idle_valid got %b want 0", out_valid); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        l = -1;
        r = 'x;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin l = i; r = result; break; end
        end
        n_cmp++; if (r !== 32'd30) begin n_err++; $display("FAIL bp_second_result got %h want 0000001e", r); end
        n_cmp++; if (l !== 33) begin n_err++; $display("FAIL bp_second_latency got %0d want 33", l); end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abort();
        int          rises;
        int          l;
        logic [31:0] r;
        operator = MD_MUL; a = 32'd1000; b = 32'd1000; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort_calc_ready got %b want 1", in_ready); end
        rises = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0) rises++;
        end
        n_cmp++; if (rises !== 0) begin n_err++; $display("FAIL abort_calc_no_valid got %0d valid cycles want 0", rises); end
        do_op(1'b0, MD_MUL, 32'hFFFFFFF4, 32'hFFFFFFF4, r, l);
        n_cmp++; if (r !== 32'd144) begin n_err++; $display("FAIL abort_next_result got %h want 00000090", r); end
        n_cmp++; if (l !== 33) begin n_err++; $display("FAIL abort_next_latency got %0d want 33", l); end
    endtask

    task automatic test_abort_done();
        operator = MD_DIVU; a = 32'd7; b = 32'd0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL abort_done_pre_valid got %b want 1", out_valid); end
        abort = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL abort_done_valid got %b want 0", out_valid); end
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort_done_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL abort_done_after got %b want 0", out_valid); end
        in_valid = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; abort = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort_accept_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL abort_accept_valid got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        int rises;
        operator = MD_MUL; a = 32'd30; b = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
        n_cmp++; if (result !== 32'd0) begin n_err++; $display("FAIL rst_mid_result got %h want 0", result); end
        rises = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0) rises++;
        end
        n_cmp++; if (rises !== 0) begin n_err++; $display("FAIL rst_mid_no_valid got %0d valid cycles want 0", rises); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_early_out();
        test_full_latency();
        test_backpressure();
        test_abort();
        test_abort_done();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
